aes_decrypt_core: RTL and testbench

//  Iterative AES-128 inverse cipher (FIPS-197), one round per clock. Inverse of the AES_top encrypt path.

---
 rtl/aes_pkg.sv | 97 +++++++++
 rtl/aes_inv_round.sv | 22 ++
 rtl/aes_decrypt_core.sv | 105 ++++++++++
 tb/tb_aes_decrypt_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared types, byte tables and GF(2^8) helpers for the iterative inverse cipher.
// State/key byte i of a 128-bit word lives at [127-8*i -: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ADDK, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; InvMixColumns only needs 9, 11, 13, 14.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
            gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(p[23:16]), sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])} ^ {rc, 24'h0};
    w0 = p[127:96] ^ t;
    w1 = p[95:64]  ^ w0;
    w2 = p[63:32]  ^ w1;
    w3 = p[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns per column unless this is the closing round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] result
);

  logic [127:0] ark, mixed;

  assign ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign mixed[127-32*g -: 32] = inv_mix_col(ark[127-32*g -: 32]);
  end

  assign result = last ? ark : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor, one round per clock, with a cached 11-entry key schedule
// so consecutive blocks under an unchanged key skip the 10-cycle expansion.
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  state_t       state;
  logic [3:0]   kc, rnd;
  logic [127:0] st;
  logic [127:0] rk [0:NR];
  logic         cache_vld;
  logic [127:0] round_res;
  logic         accept, hit, last_round;

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = in_valid && in_ready;
  // Compare against the latched key, so any key change between blocks re-expands.
  assign hit        = KEY_CACHE && cache_vld && (key == rk[0]);
  assign last_round = (state == S_FINAL);

  // rnd reaches 0 by FINAL, so rk[rnd] selects rk[0] for the closing round.
  aes_inv_round u_round (
    .st     (st),
    .rk     (rk[rnd]),
    .last   (last_round),
    .result (round_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      kc        <= '0;
      rnd       <= '0;
      st        <= '0;
      cache_vld <= 1'b0;
      out_valid <= 1'b0;
      plain_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          st <= cipher_in;
          if (hit) begin
            state <= S_ADDK;
          end else begin
            cache_vld <= 1'b0;
            kc        <= 4'd1;
            state     <= S_KEXP;
          end
        end
        S_KEXP: begin
          if (kc == 4'(NR)) begin
            cache_vld <= 1'b1;
            state     <= S_ADDK;
          end else begin
            kc <= kc + 4'd1;
          end
        end
        S_ADDK: begin
          st    <= st ^ rk[NR];
          rnd   <= 4'(NR - 1);
          state <= S_ROUND;
        end
        S_ROUND: begin
          st  <= round_res;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) state <= S_FINAL;
        end
        S_FINAL: begin
          plain_out <= round_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Schedule storage is not reset; cache_vld alone decides whether it is usable.
  always_ff @(posedge clk) begin
    if (accept)
      rk[0] <= key;
    else if (state == S_KEXP)
      rk[kc] <= next_round_key(rk[kc - 4'd1], rcon(kc));
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS-197 vectors, cache hit/miss latency, stall, mid-op reset,
// and random round trips through an arithmetic (table-free) AES encrypt model.
module tb_aes_decrypt_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] cipher_in = '0, key = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] plain_out;

  int errors = 0, checks = 0;
  logic [7:0] sb [256];
  bit model_cv;
  logic [127:0] model_key;

  always #5 clk = ~clk;

  aes_decrypt_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_in(cipher_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .plain_out(plain_out), .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_tables();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gm(inv, 8'(i));
      end
      sb[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  task automatic do_block(input logic [127:0] c, input logic [127:0] k, input bit take,
                          output int lat, output logic [127:0] pt);
    int w;
    lat = -1;
    @(negedge clk);
    cipher_in = c; key = k; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    pt = plain_out;
    if (take && lat > 0) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (plain_out !== '0) begin errors++; $display("FAIL reset_plain_out got=%h want=0", plain_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    model_cv = 1'b0;
  endtask

  task automatic test_fips_c1();
    int lat; logic [127:0] pt;
    do_block(C1_CT, C1_KEY, 1'b1, lat, pt);
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL c1_plain got=%h want=%h", pt, C1_PT); end
    checks++; if (lat !== 21) begin errors++; $display("FAIL c1_latency got=%0d want=21", lat); end
    checks++; if (dut.rk[10] !== C1_RK10) begin errors++; $display("FAIL c1_rk10 got=%h want=%h", dut.rk[10], C1_RK10); end
    model_cv = 1'b1; model_key = C1_KEY;
  endtask

  task automatic test_cache_hit();
    int lat; logic [127:0] pt;
    do_block(C1_CT, C1_KEY, 1'b1, lat, pt);
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL hit_plain got=%h want=%h", pt, C1_PT); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL hit_latency got=%0d want=11", lat); end
  endtask

  task automatic test_fips_b();
    int lat; logic [127:0] pt;
    do_block(B_CT, B_KEY, 1'b1, lat, pt);
    checks++; if (pt !== B_PT) begin errors++; $display("FAIL b_plain got=%h want=%h", pt, B_PT); end
    checks++; if (lat !== 21) begin errors++; $display("FAIL b_latency got=%0d want=21", lat); end
    model_cv = 1'b1; model_key = B_KEY;
  endtask

  task automatic test_stall();
    int lat; logic [127:0] pt;
    do_block(B_CT, B_KEY, 1'b0, lat, pt);
    checks++; if (lat !== 11) begin errors++; $display("FAIL stall_latency got=%0d want=11", lat); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || plain_out !== B_PT || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b r=%b p=%h want v=1 r=0 p=%h", i, out_valid, in_ready, plain_out, B_PT);
      end
    end
    // Accept while a new block is offered: the offer must not start in the same cycle.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; cipher_in = C1_CT; key = C1_KEY;
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL done_ignores_in got busy=%b v=%b want 0 0", busy, out_valid); end
    checks++; if (plain_out !== B_PT) begin errors++; $display("FAIL plain_kept got=%h want=%h", plain_out, B_PT); end
    do_block(B_CT, B_KEY, 1'b1, lat, pt);
    checks++; if (lat !== 11 || pt !== B_PT) begin errors++; $display("FAIL post_stall got lat=%0d p=%h want 11 %h", lat, pt, B_PT); end
  endtask

  task automatic test_reset_midop();
    int lat; logic [127:0] pt;
    do_block(C1_CT, C1_KEY, 1'b1, lat, pt);
    checks++; if (lat !== 21 || pt !== C1_PT) begin errors++; $display("FAIL keychg got lat=%0d p=%h want 21 %h", lat, pt, C1_PT); end
    @(negedge clk); cipher_in = C1_CT; key = C1_KEY; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%b r=%b b=%b want 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    model_cv = 1'b0;
    do_block(C1_CT, C1_KEY, 1'b1, lat, pt);
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL rerun_plain got=%h want=%h", pt, C1_PT); end
    checks++; if (lat !== 21) begin errors++; $display("FAIL rerun_latency got=%0d want=21", lat); end
    model_cv = 1'b1; model_key = C1_KEY;
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic [127:0] k, p, c, got;
    for (int n = 0; n < 1000; n++) begin
      if (model_cv && $urandom_range(0, 3) == 0) k = model_key;
      else k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = model_encrypt(p, k);
      exp_lat = (model_cv && k == model_key) ? 11 : 21;
      do_block(c, k, 1'b1, lat, got);
      checks++; if (got !== p) begin errors++; $display("FAIL rt_plain n=%0d got=%h want=%h", n, got, p); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rt_latency n=%0d got=%0d want=%0d", n, lat, exp_lat); end
      model_cv = 1'b1; model_key = k;
    end
  endtask

  initial begin
    init_tables();
    test_reset();
    test_fips_c1();
    test_cache_hit();
    test_fips_b();
    test_stall();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
